cnt_event_logger: RTL

CNT_EVENT_LOGGER -- requirements
Module: cnt_event_logger

---
 rtl/cnt_event_logger_pkg.sv | 15 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/cnt_event_logger.sv | 87 ++++++++
 3 files changed

// File: rtl/cnt_event_logger_pkg.sv
// Shared types and default parameters for the counter event logger.
package cnt_event_logger_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DW    = 4;
    localparam int DEF_TSW   = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_TERM  = 'hf;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO succeeds when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    // Head is masked while empty so the output reads zero out of reset.
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/cnt_event_logger.sv
// Logs timestamped changes of a monitored counter into a FIFO until the terminal count is seen.
module cnt_event_logger
    import cnt_event_logger_pkg::*;
#(
    parameter int          DW    = DEF_DW,
    parameter int          TSW   = DEF_TSW,
    parameter int          DEPTH = DEF_DEPTH,
    parameter logic [DW-1:0] TERM = DW'(DEF_TERM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DW-1:0]     cnt_in,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [TSW+DW-1:0] ev_data,
    output logic              done,
    output logic              ovf
);

    state_t         state;
    state_t         state_nx;
    logic [TSW-1:0] ts;
    logic           first;
    logic [DW-1:0]  cnt_prev_p1;
    logic           ev_push;
    logic           is_term;
    logic           fifo_full;
    logic           fifo_empty;

    assign ev_push  = (state == RUN) && (first || (cnt_in != cnt_prev_p1));
    assign is_term  = ev_push && (cnt_in == TERM);
    assign ev_valid = !fifo_empty;
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)   state_nx = RUN;
            RUN:     if (is_term) state_nx = DONE;
            DONE:    if (start)   state_nx = RUN;
            default:              state_nx = IDLE;
        endcase
    end

    // Run bookkeeping: a drop only counts when the FIFO is full and nothing leaves this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts    <= '0;
            first <= 1'b0;
            ovf   <= 1'b0;
        end else if ((state != RUN) && start) begin
            ts    <= '0;
            first <= 1'b1;
            ovf   <= 1'b0;
        end else if (state == RUN) begin
            ts    <= ts + 1'b1;
            first <= 1'b0;
            if (ev_push && fifo_full && !ev_ready) ovf <= 1'b1;
        end
    end

    // p1: previous-cycle counter value for change detection
    always_ff @(posedge clk) begin
        cnt_prev_p1 <= cnt_in;
    end

    sync_fifo #(
        .WIDTH (TSW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev_push),
        .wdata ({ts, cnt_in}),
        .pop   (ev_ready),
        .rdata (ev_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
